// File: rtl/result_serializer.sv
// Buffers 32-bit multiplier results in a circular buffer and streams each one out
// as two 16-bit half-words (upper first) over a valid/ready handshake.
module result_serializer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          done_in,
    input  logic [31:0]   result_in,
    output logic          full,
    output logic [15:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_HI    = 2'd1;
    localparam logic [1:0] S_LO    = 2'd2;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic          overflow_q, overflow_d;
    logic          full_w, wr, pop;
    logic [31:0]   head;

    // Full comes from registered count only, so a coinciding pop cannot rescue a write.
    always_comb begin
        full_w = (count_q == CW'(DEPTH));
        wr     = done_in & ~full_w;
        pop    = (state_q == S_LO) & out_ready;
        head   = mem_q[rptr_q];

        wptr_d     = wr  ? wptr_q + AW'(1) : wptr_q;
        rptr_d     = pop ? rptr_q + AW'(1) : rptr_q;
        overflow_d = overflow_q | (done_in & full_w);

        count_d = count_q;
        case ({wr, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        state_d = state_q;
        case (state_q)
            S_EMPTY: if (wr) state_d = S_HI;
            S_HI:    if (out_ready) state_d = S_LO;
            S_LO:    if (out_ready) state_d = (count_d != '0) ? S_HI : S_EMPTY;
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            state_q    <= S_EMPTY;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && wr) mem_q[wptr_q] <= result_in;
    end

    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 16'h0000;
        case (state_q)
            S_HI: begin
                out_valid = 1'b1;
                out_data  = head[31:16];
            end
            S_LO: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = head[15:0];
            end
            default: ;
        endcase
    end

    assign full     = full_w;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_result_serializer.sv
// Scoreboard bench: the driver pushes expected half-words for every accepted result,
// and an independent monitor pops and compares them on each output transfer.
module tb_result_serializer;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          done_in = 1'b0;
    logic [31:0]   result_in = '0;
    logic          out_ready = 1'b0;
    logic          full, out_valid, out_last, overflow;
    logic [15:0]   out_data;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_pass   = 0;

    // Each element is {last, half-word}; two per accepted result.
    logic [16:0] exp_q[$];
    logic        ovf_exp = 1'b0;

    always #5 clk = ~clk;

    result_serializer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .done_in   (done_in),
        .result_in (result_in),
        .full      (full),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .count     (count),
        .overflow  (overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Entries stored = half-words outstanding rounded up (a half-sent entry still counts).
    task automatic check_state();
        int ents;
        ents = (exp_q.size() + 1) / 2;
        chk("count", 32'(count), 32'(ents));
        chk("full", 32'(full), 32'(ents == DEPTH));
        chk("overflow", 32'(overflow), 32'(ovf_exp));
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() == 0) begin
            chk("idle_data", 32'(out_data), 32'h0);
            chk("idle_last", 32'(out_last), 32'h0);
        end
    endtask

    // One cycle: check the state left by the previous edge, then drive the next one.
    task automatic step(input logic d, input logic [31:0] r, input logic rdy, input logic rs);
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            ovf_exp = 1'b0;
        end
        check_state();
        done_in   = d;
        result_in = r;
        out_ready = rdy;
        rst       = rs;
        if (!rs && d) begin
            if ((exp_q.size() + 1) / 2 == DEPTH) ovf_exp = 1'b1;
            else begin
                exp_q.push_back({1'b0, r[31:16]});
                exp_q.push_back({1'b1, r[15:0]});
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(out_valid), 32'h0);
            end else begin
                chk("out_data", 32'(out_data), 32'(exp_q[0][15:0]));
                chk("out_last", 32'(out_last), 32'(exp_q[0][16]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        // Single entry, free-flowing
        step(1'b1, 32'h1234_ABCD, 1'b1, 1'b0);
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Backpressure holds the upper half
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        repeat (5) step(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Fill to DEPTH, fifth write dropped
        for (int i = 1; i <= 5; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (10) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Reset with a coinciding done_in clears overflow and ignores the write
        step(1'b1, 32'hFFFF_0000, 1'b0, 1'b1);
        repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Wrap: ten writes interleaved with continuous drain
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'hA000_0000 + 32'(i * 32'h0001_0001), 1'b1, 1'b0);
            step(1'b0, 32'h0, 1'b1, 1'b0);
        end
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Write coinciding with a pop from S_LO while count is 2
        step(1'b1, 32'h1111_2222, 1'b0, 1'b0);
        step(1'b1, 32'h3333_4444, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h5555_6666, 1'b1, 1'b0);
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Reset while serializing the low half with three entries stored
        for (int i = 0; i < 3; i++) step(1'b1, 32'hC0DE_0000 + 32'(i), 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 63) == 0));
        end

        for (int i = 0; i < 3 * DEPTH; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain_empty", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/result_serializer.md
RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 Parameter DEPTH, default 4, number of 32-bit result entries buffered; power of two, minimum 2.
REQ-002 Parameter CW, default 3, width of count output; equals log2(DEPTH)+1.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 done_in  input  1  one-cycle pulse from the multiplier controller; result_in is valid in that cycle.
REQ-007 result_in  input  32  product from the multiplier datapath, {upper half, lower half}.
REQ-008 full  output  1  high when count equals DEPTH; the upstream controller stalls on it.
REQ-009 out_data  output  16  current output half-word.
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 out_last  output  1  high while the low half of an entry is presented.
REQ-013 count  output  CW  number of entries stored, including the entry currently being serialized.
REQ-014 overflow  output  1  sticky; set when a result is dropped.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH x 32 bits with write and read pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-016 Write: done_in=1 and full=0 at a rising edge stores result_in at the write pointer, increments the write pointer, and increments count.
REQ-017 Drop: done_in=1 and full=1 leaves storage, pointers and count unchanged and sets overflow to 1.
REQ-018 Full is evaluated before any pop in the same cycle: a write that coincides with a pop while full SHALL still be dropped.
REQ-019 The serializer FSM SHALL have three states:
- S_EMPTY: count=0.
- S_HI: head upper half presented.
- S_LO: head lower half presented.
REQ-020 S_EMPTY drives out_valid=0, out_last=0 and out_data=0.
REQ-021 S_HI drives out_valid=1, out_last=0 and out_data=head[31:16].
REQ-022 S_LO drives out_valid=1, out_last=1 and out_data=head[15:0].
REQ-023 Transfer is out_valid & out_ready; out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-024 S_EMPTY goes to S_HI at the edge where a write occurs.
REQ-025 S_HI goes to S_LO on a transfer and stays in S_HI otherwise.
REQ-026 S_LO on a transfer pops the head: it increments the read pointer and decrements count.
REQ-027 After that pop, S_LO goes to S_HI if entries remain, counting a same-cycle write, and to S_EMPTY otherwise.
REQ-028 Simultaneous write and pop while not full SHALL leave count unchanged and move both pointers.
REQ-029 Latency: a write at edge N SHALL give out_valid=1 with the upper half after edge N, with no combinational path from done_in or result_in to the outputs.
REQ-030 Throughput: with out_ready held high, one half-word SHALL be transferred per cycle with no bubbles while count>0.
REQ-031 full and count are registered-state-derived, with no combinational dependence on done_in or out_ready.
REQ-032 Read data SHALL come from the head entry in storage, not from result_in.
REQ-033 overflow SHALL clear only on rst.

Reset
REQ-034 When rst=1 at a clock edge, the FSM SHALL go to S_EMPTY and pointers, count and overflow SHALL be cleared.
REQ-035 Reset outputs: out_valid=0, out_last=0, out_data=0, full=0, count=0, overflow=0.
REQ-036 Reset mid-serialization SHALL discard all stored entries, including a half-sent entry.
REQ-037 A done_in asserted in the same cycle as rst SHALL be ignored.
REQ-038 Storage contents need not be cleared.

Verification
REQ-039 Single entry: write 0x1234_ABCD, out_ready=1 -> 0x1234 with out_last=0 next cycle, then 0xABCD with out_last=1, then out_valid=0 and count=0.
REQ-040 Backpressure: write 0xDEAD_BEEF, out_ready=0 for 5 cycles -> out_data holds 0xDEAD; releasing out_ready gives 0xDEAD then 0xBEEF.
REQ-041 Fill and overflow: 5 writes of 0x0000_0001..0x0000_0005 with out_ready=0 -> full=1 after the 4th write, 5th dropped, overflow=1, output order 1..4.
REQ-042 Wrap: 10 writes interleaved with continuous drain -> all 20 half-words in order, pointers wrapping twice, overflow=0.
REQ-043 Simultaneous events: count=2 in S_LO, write coincides with pop -> count stays 2 and the FSM goes to S_HI.
REQ-044 Reset mid-operation: rst asserted in S_LO with count=3 -> next cycle out_valid=0, count=0, full=0, overflow=0.
